// File: rtl/fir_seq_ctrl.sv
`timescale 1ns/1ps
// fir_seq_ctrl: primes, feeds and flushes a free-running transposed FIR and tags its output.
// Optional macro FIR_AUTO_FLUSH_EN: auto-flush after IDLE_TIMEOUT consecutive underrun cycles.
module fir_seq_ctrl #(
    parameter int NUMTAPS      = 32,
    parameter int DW           = 12,
    parameter int FIR_LAT      = 1,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          S_Valid,
    output logic          S_Ready,
    input  logic [DW-1:0] S_Data,
    input  logic          Flush_Req,
    input  logic          Cnt_Clr,
    output logic          Fir_Hlt,
    output logic [DW-1:0] Fir_Din,
    input  logic [DW-1:0] Fir_Dout,
    output logic          M_Valid,
    output logic [DW-1:0] M_Data,
    output logic          M_Last,
    output logic          Busy,
    output logic [15:0]   Sample_Cnt,
    output logic [15:0]   Underrun_Cnt
);
    localparam int PRIME_LEN = NUMTAPS + FIR_LAT + 1;
    localparam int CW        = $clog2(PRIME_LEN) + 1;
    localparam logic [CW-1:0] PRIME_END = CW'(PRIME_LEN - 1);
    localparam logic [CW-1:0] FLUSH_END = CW'(NUMTAPS - 1);

    typedef enum logic [1:0] {PRIME, IDLE, RUN, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hlt_q, hlt_d;
    logic [FIR_LAT:0] vld_pipe, last_pipe;
    logic            m_valid_q, m_last_q;
    logic [DW-1:0]   m_data_q;
    logic [15:0]     scnt_q, scnt_d, ucnt_q, ucnt_d;
    logic            run, feed, accept, underrun, flush_last, auto_flush;

    assign run        = (state_q == RUN);
    assign feed       = run || (state_q == FLUSH);
    assign accept     = run && S_Valid;
    assign underrun   = run && !S_Valid;
    assign flush_last = (state_q == FLUSH) && (cnt_q == FLUSH_END);

`ifdef FIR_AUTO_FLUSH_EN
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_END = IW'(IDLE_TIMEOUT - 1);
    logic [IW-1:0] idle_q, idle_d;
    // Streak resets on any accepted sample and whenever RUN is left.
    assign auto_flush = underrun && (idle_q == IDLE_END);
    assign idle_d     = underrun ? idle_q + 1'b1 : '0;
`else
    assign auto_flush = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            PRIME: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == PRIME_END) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE:  if (S_Valid) state_d = RUN;
            RUN: begin
                if (Flush_Req || auto_flush) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            default: begin
                cnt_d = cnt_q + 1'b1;
                if (flush_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
        // Hlt follows the next registered state so it comes straight off a flop.
        hlt_d  = (state_d == PRIME) || (state_d == IDLE);
        scnt_d = Cnt_Clr ? 16'd0 : (accept ? scnt_q + 16'd1 : scnt_q);
        ucnt_d = Cnt_Clr ? 16'd0 :
                 ((underrun && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= PRIME;
            cnt_q     <= '0;
            hlt_q     <= 1'b1;
            vld_pipe  <= '0;
            last_pipe <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            scnt_q    <= '0;
            ucnt_q    <= '0;
`ifdef FIR_AUTO_FLUSH_EN
            idle_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hlt_q        <= hlt_d;
            scnt_q       <= scnt_d;
            ucnt_q       <= ucnt_d;
`ifdef FIR_AUTO_FLUSH_EN
            idle_q       <= idle_d;
`endif
            vld_pipe[0]  <= feed;
            last_pipe[0] <= flush_last;
            for (int i = 1; i <= FIR_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            m_valid_q <= vld_pipe[FIR_LAT];
            m_last_q  <= last_pipe[FIR_LAT];
            if (vld_pipe[FIR_LAT]) m_data_q <= Fir_Dout;
        end
    end

    assign S_Ready      = run;
    assign Fir_Din      = accept ? S_Data : '0;
    assign Fir_Hlt      = hlt_q;
    assign M_Valid      = m_valid_q;
    assign M_Data       = m_data_q;
    assign M_Last       = m_last_q;
    assign Busy         = (state_q != IDLE);
    assign Sample_Cnt   = scnt_q;
    assign Underrun_Cnt = ucnt_q;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for fir_seq_ctrl; the FIR is stood in by an identity pipe of FIR_LAT+1 registers.
module tb_fir_seq_ctrl;
    localparam int NUMTAPS = 32, DW = 12, FIR_LAT = 1, IDLE_TIMEOUT = 8;
    localparam int PRIME_LEN = NUMTAPS + FIR_LAT + 1;

    logic          Clk, Rst_n, S_Valid, S_Ready, Flush_Req, Cnt_Clr;
    logic [DW-1:0] S_Data, Fir_Din, M_Data;
    logic [DW-1:0] Fir_Dout = '0;
    logic          Fir_Hlt, M_Valid, M_Last, Busy;
    logic [15:0]   Sample_Cnt, Underrun_Cnt;

    fir_seq_ctrl #(.NUMTAPS(NUMTAPS), .DW(DW), .FIR_LAT(FIR_LAT), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .S_Valid(S_Valid), .S_Ready(S_Ready), .S_Data(S_Data),
        .Flush_Req(Flush_Req), .Cnt_Clr(Cnt_Clr), .Fir_Hlt(Fir_Hlt), .Fir_Din(Fir_Din),
        .Fir_Dout(Fir_Dout), .M_Valid(M_Valid), .M_Data(M_Data), .M_Last(M_Last),
        .Busy(Busy), .Sample_Cnt(Sample_Cnt), .Underrun_Cnt(Underrun_Cnt));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Stand-in FIR: input register with async clear on Hlt, then one output register.
    logic [DW-1:0] fin_q;
    always @(posedge Clk or posedge Fir_Hlt)
        if (Fir_Hlt) fin_q <= '0;
        else         fin_q <= Fir_Din;
    always @(posedge Clk) Fir_Dout <= fin_q;

    typedef enum int {M_PRIME, M_IDLE, M_RUN, M_FLUSH} mst_t;
    typedef struct {logic [DW-1:0] d; logic l; int due;} exp_t;

    exp_t          q[$];
    mst_t          ms;
    int            cyc = 0, mcnt = 0, streak = 0;
    logic [15:0]   m_scnt = '0, m_ucnt = '0;
    logic [DW-1:0] m_last_data = '0;
    int            errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: every word fed in RUN/FLUSH comes back FIR_LAT+1 edges later.
    initial begin
        ms = M_PRIME;
        forever begin
            @(posedge Clk or negedge Rst_n);
            if (!Rst_n) begin
                ms = M_PRIME; mcnt = 0; streak = 0; m_scnt = '0; m_ucnt = '0; q.delete();
            end else begin
                exp_t e;
                logic go_flush;
                cyc++;
                e.due = cyc + FIR_LAT + 1;
                case (ms)
                    M_PRIME: begin
                        mcnt++;
                        if (mcnt == PRIME_LEN) begin ms = M_IDLE; mcnt = 0; end
                    end
                    M_IDLE: if (S_Valid) ms = M_RUN;
                    M_RUN: begin
                        e.d = S_Valid ? S_Data : '0; e.l = 1'b0; q.push_back(e);
                        if (S_Valid) m_scnt++;
                        else if (m_ucnt != 16'hFFFF) m_ucnt++;
                        streak = S_Valid ? 0 : streak + 1;
                        go_flush = Flush_Req;
`ifdef FIR_AUTO_FLUSH_EN
                        if (streak == IDLE_TIMEOUT) go_flush = 1'b1;
`endif
                        if (go_flush) begin ms = M_FLUSH; mcnt = 0; streak = 0; end
                    end
                    M_FLUSH: begin
                        mcnt++;
                        e.d = '0; e.l = (mcnt == NUMTAPS); q.push_back(e);
                        if (mcnt == NUMTAPS) begin ms = M_IDLE; mcnt = 0; end
                    end
                endcase
                if (Cnt_Clr) begin m_scnt = '0; m_ucnt = '0; end
            end
        end
    end

    // Monitor: pops the scoreboard whenever an output is due and checks control outputs.
    initial begin
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                m_last_data = '0;
                chk("rst_m_valid", M_Valid, 0);
                chk("rst_m_last", M_Last, 0);
                chk("rst_m_data", M_Data, 0);
                chk("rst_hlt", Fir_Hlt, 1);
                chk("rst_ready", S_Ready, 0);
                chk("rst_sample_cnt", Sample_Cnt, 0);
                chk("rst_underrun_cnt", Underrun_Cnt, 0);
            end else begin
                logic due;
                due = (q.size() > 0) && (q[0].due == cyc);
                chk("m_valid", M_Valid, due);
                if (due) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("m_data", M_Data, e.d);
                    chk("m_last", M_Last, e.l);
                    m_last_data = e.d;
                end else begin
                    chk("m_last_idle", M_Last, 0);
                    chk("m_data_hold", M_Data, m_last_data);
                end
                chk("s_ready", S_Ready, ms == M_RUN);
                chk("fir_hlt", Fir_Hlt, (ms == M_PRIME) || (ms == M_IDLE));
                chk("busy", Busy, ms != M_IDLE);
                chk("fir_din", Fir_Din, (ms == M_RUN && S_Valid) ? S_Data : '0);
                chk("sample_cnt", Sample_Cnt, m_scnt);
                chk("underrun_cnt", Underrun_Cnt, m_ucnt);
            end
        end
    end

    task automatic step();
        @(posedge Clk); #1;
    endtask

    task automatic idle_inputs();
        S_Valid = 1'b0; S_Data = '0; Flush_Req = 1'b0; Cnt_Clr = 1'b0;
    endtask

    // Holds a sample until the model's state says it is taken at the coming edge.
    task automatic send(input logic [DW-1:0] d);
        logic acc;
        S_Valid = 1'b1; S_Data = d;
        for (int i = 0; i < 60; i++) begin
            acc = (ms == M_RUN);
            step();
            if (acc) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        Rst_n = 1'b0; idle_inputs();
        repeat (3) step();
        Rst_n = 1'b1;
        repeat (40) step();
        Flush_Req = 1'b1; step(); Flush_Req = 1'b0;
        send(12'h7FF);
        for (int i = 0; i < 20; i++) send(12'h000);
        for (int i = 0; i < 40; i++) send(12'h100);
        S_Valid = 1'b0; repeat (3) step();
        for (int i = 0; i < 5; i++) send(DW'($urandom));
        // Flush request together with a valid sample, then let the tail drain.
        S_Valid = 1'b1; S_Data = DW'($urandom); Flush_Req = 1'b1; step();
        Flush_Req = 1'b0; S_Valid = 1'b0;
        repeat (40) step();
        // Reset while the 10th flush word is being fed.
        for (int i = 0; i < 10; i++) send(DW'($urandom));
        Flush_Req = 1'b1; step(); Flush_Req = 1'b0; S_Valid = 1'b0;
        repeat (9) step();
        Rst_n = 1'b0; repeat (2) step(); Rst_n = 1'b1;
        repeat (40) step();
        for (int i = 0; i < 2500; i++) begin
            S_Valid   = ($urandom % 10) < 7;
            S_Data    = DW'($urandom);
            Flush_Req = ($urandom % 50) == 0;
            Cnt_Clr   = ($urandom % 40) == 0;
            if (($urandom % 400) == 0) begin
                Rst_n = 1'b0; step(); Rst_n = 1'b1;
            end
            step();
        end
        idle_inputs();
        repeat (50) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Sequencer for the 32-tap transposed FIR (12-bit in, 12-bit out, free-running datapath, async-clear Hlt on input register only).
- Primes the FIR's sum chain after reset and gates its Hlt pin glitch-free.
- Admits upstream samples with valid/ready, zero-stuffs gaps, and tags FIR outputs with valid/last.
- Runs an explicit flush that drains the convolution tail.

Parameters:
NUMTAPS, 32, FIR tap count; sets prime length and flush length
DW, 12, sample width in and out
FIR_LAT, 1, clock edges after the feeding edge before Fir_Dout reflects that sample
IDLE_TIMEOUT, 8, consecutive underrun cycles that trigger auto-flush (used only with FIR_AUTO_FLUSH_EN)

Ports:
Clk  in  1  clock
Rst_n  in  1  asynchronous active-low reset
S_Valid  in  1  upstream sample valid
S_Ready  out  1  upstream ready
S_Data  in  DW  upstream signed sample
Flush_Req  in  1  single-cycle flush request
Cnt_Clr  in  1  synchronous clear of both counters
Fir_Hlt  out  1  to FIR Hlt; driven directly from a flop
Fir_Din  out  DW  to FIR Din
Fir_Dout  in  DW  from FIR Dout
M_Valid  out  1  output sample valid; downstream cannot stall
M_Data  out  DW  registered output sample
M_Last  out  1  final sample of a flush tail
Busy  out  1  high in all states except IDLE
Sample_Cnt  out  16  accepted real samples; wraps
Underrun_Cnt  out  16  zero-stuffed RUN cycles; saturates at 16'hFFFF

Behaviour:
- Reset (Rst_n low, async): state=PRIME, prime counter=0, Fir_Hlt=1, M_Valid=0, M_Data=0, M_Last=0, both counters 0, tag delay line cleared.
- Fir_Hlt is a flop output, never combinational, because it drives the FIR's async clear. Fir_Hlt=1 exactly while the registered state is PRIME or IDLE.
- Fir_Din is combinational: S_Data when state=RUN and S_Valid=1, otherwise 0.
- PRIME: S_Ready=0. Lasts NUMTAPS+FIR_LAT+1 cycles (34 at default) so zero products clear the sum chain, then -> IDLE.
- IDLE: S_Ready=0 and Flush_Req is ignored. When S_Valid=1, go to RUN at the next edge; Fir_Hlt deasserts at that same edge. The first sample is accepted in the following cycle, so start cost is 1 cycle.
- RUN: S_Ready=1.
  - Every cycle feeds one word into the FIR and pushes a tag=1 into the delay line.
  - S_Valid=1: accepted; Sample_Cnt increments.
  - S_Valid=0: zero fed; Underrun_Cnt increments (saturating).
  - Flush_Req=1: that cycle's sample is still accepted, then -> FLUSH at the next edge.
- FLUSH: S_Ready=0; exactly NUMTAPS zero words fed, each tagged. The last tag carries last=1. After the NUMTAPS-th word -> IDLE. Flush_Req is ignored in FLUSH.
- Output timing:
  - A word fed at edge t is captured as M_Data<=Fir_Dout at edge t+FIR_LAT+1, with M_Valid=tag and M_Last=last.
  - Outputs are continuous in RUN and FLUSH.
  - The M_Last cycle is followed by M_Valid=0 (the IDLE pipeline holds no tags).
  - M_Data holds its last value while M_Valid=0.
- Counters: Cnt_Clr zeroes both at the next edge; it takes priority over any increment in the same cycle.
- Simultaneous S_Valid with RUN->FLUSH transition: the sample is accepted, and the flush starts on the next word.
- Reset mid-RUN or mid-FLUSH: outputs go to reset values immediately, the tail is discarded, and the block re-enters PRIME. No M_Last is emitted.

Optional Feature:
- Macro FIR_AUTO_FLUSH_EN.
- Defined: in RUN, a counter tracks consecutive underrun cycles and resets on any accepted sample. When it reaches IDLE_TIMEOUT, the block enters FLUSH at the next edge exactly as if Flush_Req had been asserted. Those IDLE_TIMEOUT zeros are tagged and output normally.
- Undefined: the counter and this path are absent; RUN persists indefinitely until Flush_Req or reset.

Test Plan:
- Release Rst_n -> Fir_Hlt=1, S_Ready=0, M_Valid=0 for exactly 34 cycles; then IDLE with Busy=0.
- IDLE, S_Valid=1 with 12'h7FF, then continuous 0 samples -> S_Ready rises 1 cycle after S_Valid. Starting 2 edges after the impulse is fed, M_Data reads 12'hFFD, 000, 000, 003, 009, ...; the 16th output is 12'd172.
- Continuous 12'h100 -> after 32 samples M_Data steady at 12'h117 (256*2236>>11).
- In RUN, S_Valid low for 3 cycles -> Underrun_Cnt +3, M_Valid stays continuous, Sample_Cnt unchanged across the gap.
- Flush_Req pulse in RUN with S_Valid=1 -> that sample is counted; exactly 32 further M_Valid cycles, M_Last on the 32nd only; then M_Valid=0, Fir_Hlt=1, Busy=0.
- Rst_n low at the 10th flush word -> M_Valid=0 immediately, no M_Last, 34-cycle PRIME repeats. With FIR_AUTO_FLUSH_EN, 8 idle RUN cycles cause auto-flush and M_Last appears 40 outputs after the last real sample.
